// File: rtl/arduino_uart_buffer.sv
`default_nettype none
// ============================================================================
// Module      : arduino_uart_buffer
// Description : 8N1 UART receiver for the Arduino serial link, followed by a
//               one-word valid/ready output buffer feeding the command decoder.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLKS_PER_BIT : clk_50 cycles per UART bit period (>= 4)
//   BITS_N       : data bits per frame / width of arduino_command
// Ports
//   clk_50          in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   arduino_input   in   asynchronous serial RX line, idle high
//   ready           in   downstream accepts the buffered word this cycle
//   valid           out  arduino_command holds an unconsumed word
//   arduino_command out  last received data word (BITS_N bits)
// ============================================================================
module arduino_uart_buffer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              arduino_input,
    input  logic              ready,
    output logic              valid,
    output logic [BITS_N-1:0] arduino_command
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (BITS_N > 1) ? $clog2(BITS_N) : 1;

    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(BITS_N - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Synchroniser chain; rx_prev_q keeps the previous synchronised sample
    // so a start bit is recognised only as a genuine 1->0 transition.
    logic              sync1_q;
    logic              rx_q;
    logic              rx_prev_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BITS_N-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;
    logic [BITS_N-1:0] cmd_q, cmd_d;
    logic              word_done;

    // Receiver next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_prev_q && !rx_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A line back high at mid start bit was a glitch.
                    state_d = rx_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_q;
                    if (idx_q == C_IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + C_IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    // A low stop bit is a framing error: the word is dropped.
                    word_done = rx_q;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Output buffer: a transfer empties the slot; a finished word is taken
    // only if the slot is empty or is being emptied on this same edge.
    always_comb begin
        valid_d = valid_q;
        cmd_d   = cmd_q;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (word_done && (!valid_q || ready)) begin
            valid_d = 1'b1;
            cmd_d   = shift_q;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            rx_q      <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            cmd_q     <= '0;
        end else begin
            sync1_q   <= arduino_input;
            rx_q      <= sync1_q;
            rx_prev_q <= rx_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
        end
    end

    assign valid           = valid_q;
    assign arduino_command = cmd_q;

endmodule
`default_nettype wire

// File: tb/tb_arduino_uart_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_arduino_uart_buffer
// Description : Directed self-checking bench for arduino_uart_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arduino_uart_buffer;

    localparam int CLKS = 434;
    // Input change -> valid: sync (2) + half bit + 9 bit periods + 1
    localparam int EXP_LAT = CLKS / 2 + 9 * CLKS + 3;

    logic       clk_50 = 1'b0;
    logic       reset  = 1'b1;
    logic       arduino_input = 1'b1;
    logic       ready  = 1'b0;
    logic       valid;
    logic [7:0] arduino_command;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observation counters, written only by the monitor below
    int cyc        = 0;
    int rise_cnt   = 0;
    int high_cnt   = 0;
    int rise_cyc   = 0;
    logic v_prev   = 1'b0;
    int t_start    = 0;

    arduino_uart_buffer #(.CLKS_PER_BIT(CLKS), .BITS_N(8)) dut (
        .clk_50          (clk_50),
        .reset           (reset),
        .arduino_input   (arduino_input),
        .ready           (ready),
        .valid           (valid),
        .arduino_command (arduino_command)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    always @(negedge clk_50) begin
        if (valid === 1'b1 && v_prev !== 1'b1) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        if (valid === 1'b1) high_cnt = high_cnt + 1;
        v_prev = valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic drive_bit(input logic b);
        arduino_input = b;
        idle(CLKS);
    endtask

    // Whole frame, LSB first; stop bit level is selectable
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        @(negedge clk_50);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_b);
        arduino_input = 1'b1;
        idle(20);
    endtask

    // Good frame with ready high: one pulse of valid, right word, on time
    task automatic frame_expect(input string tag, input logic [7:0] d);
        int r0, h0, lat;
        r0 = rise_cnt;
        h0 = high_cnt;
        send_frame(d, 1'b1);
        check({tag, "_rises"}, rise_cnt - r0, 1);
        check({tag, "_pulse"}, high_cnt - h0, 1);
        check({tag, "_data"}, arduino_command, d);
        lat = rise_cyc - t_start;
        n_cmp++;
        assert (lat >= EXP_LAT - 3 && lat <= EXP_LAT + 3) else begin
            n_fail++;
            $error("FAIL %s_latency: observed %0d expected %0d+-3", tag, lat, EXP_LAT);
        end
    endtask

    initial begin
        int r0;
        // 1. Reset
        reset = 1'b1;
        #100;
        check("rst_valid", valid, 0);
        check("rst_cmd", arduino_command, 8'h00);
        @(negedge clk_50);
        reset = 1'b0;
        idle(50);
        check("post_rst_valid", valid, 0);
        check("post_rst_cmd", arduino_command, 8'h00);

        // 2. Single byte with ready high
        ready = 1'b1;
        frame_expect("aa", 8'hAA);

        // 3. Backpressure
        ready = 1'b0;
        r0 = rise_cnt;
        send_frame(8'h5A, 1'b1);
        check("bp_valid", valid, 1);
        check("bp_data", arduino_command, 8'h5A);
        send_frame(8'hC3, 1'b1);
        check("bp_drop_valid", valid, 1);
        check("bp_drop_data", arduino_command, 8'h5A);
        check("bp_rises", rise_cnt - r0, 1);
        ready = 1'b1;
        @(negedge clk_50);
        check("bp_release_valid", valid, 0);
        check("bp_release_data", arduino_command, 8'h5A);
        frame_expect("3c", 8'h3C);

        // 4. Glitch rejection
        r0 = rise_cnt;
        @(negedge clk_50);
        arduino_input = 1'b0;
        idle(100);
        arduino_input = 1'b1;
        idle(CLKS * 2);
        check("glitch_rises", rise_cnt - r0, 0);
        check("glitch_valid", valid, 0);
        frame_expect("81", 8'h81);

        // 5. Framing error: stop low, line low for two bit times
        r0 = rise_cnt;
        @(negedge clk_50);
        arduino_input = 1'b0;
        idle(CLKS);
        for (int i = 0; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        arduino_input = 1'b1;
        idle(CLKS);
        check("frm_rises", rise_cnt - r0, 0);
        check("frm_valid", valid, 0);
        check("frm_data", arduino_command, 8'h81);
        frame_expect("12", 8'h12);

        // 6. Reset in the middle of data bit 4 of 0x77
        @(negedge clk_50);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'((8'h77 >> i) & 8'h01));
        arduino_input = 1'b1;
        idle(200);
        #5 reset = 1'b1;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_cmd", arduino_command, 8'h00);
        idle(5);
        reset = 1'b0;
        idle(CLKS * 6);
        check("midrst_idle_valid", valid, 0);
        frame_expect("09", 8'h09);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
